// File: rtl/fxp_mac_vec_unit.sv
// Multi-lane fixed-point dot-product engine. Each lane accumulates signed a*b over
// cfg_length input lines, then shifts and saturates into one packed result line.
module fxp_mac_vec_unit #(
  parameter int WIDTH       = 16,
  parameter int LANES       = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [511:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [511:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cfg_start,
  input  logic [15:0]      cfg_length,
  input  logic [4:0]       cfg_shift,
  output logic             busy,
  output logic             done,
  output logic [LANES-1:0] sat_flags
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [WIDTH-1:0]            RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]            RES_MIN = ~RES_MAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_EMIT} state_t;

  state_t                       r_state;
  logic [15:0]                  r_len_m1;
  logic [15:0]                  r_count;
  logic [4:0]                   r_shift;
  logic                         r_in_ready;
  logic                         r_out_valid;
  logic [511:0]                 r_out_data;
  logic                         r_busy;
  logic                         r_done;
  logic [LANES-1:0]             r_sat;
  logic [MUL_LATENCY-1:0]       r_pv;
  logic signed [PW-1:0]         r_prod [MUL_LATENCY][LANES];
  logic signed [ACC_WIDTH-1:0]  r_acc  [LANES];

  logic                         w_accept;
  logic                         w_acc_clear;
  logic signed [PW-1:0]         w_a [LANES];
  logic signed [PW-1:0]         w_b [LANES];
  logic signed [ACC_WIDTH-1:0]  w_shifted [LANES];
  logic [LANES-1:0]             w_clamp;
  logic [511:0]                 w_pack;

  assign w_accept    = in_valid & r_in_ready;
  assign w_acc_clear = ((r_state == S_IDLE) && cfg_start) || ((r_state == S_EMIT) && out_ready);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sat_flags = r_sat;

  // Operands are sign-extended to the product width before multiplying.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_a[i] = PW'($signed(in_data[PW*i +: WIDTH]));
      w_b[i] = PW'($signed(in_data[PW*i+WIDTH +: WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv <= '0;
    end else begin
      r_pv[0] <= w_accept;
      for (int s = 1; s < MUL_LATENCY; s++) r_pv[s] <= r_pv[s-1];
    end
  end

  // NOTE: product data needs no reset; r_pv alone decides whether a stage is consumed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      r_prod[0][i] <= w_a[i] * w_b[i];
      for (int s = 1; s < MUL_LATENCY; s++) r_prod[s][i] <= r_prod[s-1][i];
    end
  end

  // Accumulators wrap silently; only the final shifted value is range-checked.
  always_ff @(posedge clk) begin
    if (reset || w_acc_clear) begin
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
    end else if (r_pv[MUL_LATENCY-1]) begin
      for (int i = 0; i < LANES; i++)
        r_acc[i] <= r_acc[i] + ACC_WIDTH'(r_prod[MUL_LATENCY-1][i]);
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_pack  = '0;
    w_clamp = '0;
    for (int i = 0; i < LANES; i++) begin
      w_shifted[i] = r_acc[i] >>> r_shift;
      if (w_shifted[i] > SAT_MAX) begin
        w_pack[WIDTH*i +: WIDTH] = RES_MAX;
        w_clamp[i]               = 1'b1;
      end else if (w_shifted[i] < SAT_MIN) begin
        w_pack[WIDTH*i +: WIDTH] = RES_MIN;
        w_clamp[i]               = 1'b1;
      end else begin
        w_pack[WIDTH*i +: WIDTH] = w_shifted[i][WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len_m1    <= '0;
      r_count     <= '0;
      r_shift     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sat       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_len_m1   <= (cfg_length == 16'd0) ? 16'd0 : 16'(cfg_length - 16'd1);
            r_shift    <= cfg_shift;
            r_sat      <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (r_count == r_len_m1) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end else begin
              r_count <= 16'(r_count + 16'd1);
            end
          end
        end
        S_DRAIN: begin
          // Empty pipe means the final product was added at the previous edge.
          if (r_pv == '0) begin
            r_out_data  <= w_pack;
            r_sat       <= r_sat | w_clamp;
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_mac_vec_unit.sv
// Directed bench for fxp_mac_vec_unit: vector table for single dot products plus
// streaming/backpressure, latency-with-gaps and mid-run reset sequences.
module tb_fxp_mac_vec_unit;

  localparam int W  = 16;
  localparam int L  = 16;
  localparam int ML = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         cfg_start = 1'b0;
  logic [15:0]  cfg_length = '0;
  logic [4:0]   cfg_shift = '0;
  logic         busy;
  logic         done;
  logic [L-1:0] sat_flags;

  fxp_mac_vec_unit #(.WIDTH(W), .LANES(L), .ACC_WIDTH(40), .MUL_LATENCY(ML)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_start(cfg_start), .cfg_length(cfg_length), .cfg_shift(cfg_shift),
    .busy(busy), .done(done), .sat_flags(sat_flags)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples at the falling edge, where every DUT output and tb input is stable.
  logic [511:0] res_q[$];
  int done_cnt = 0, acc_cnt = 0, bp_viol = 0, hold_cnt = 0;
  always @(negedge clk) begin
    if (out_valid && out_ready) res_q.push_back(out_data);
    if (done)                   done_cnt <= done_cnt + 1;
    if (in_valid && in_ready)   acc_cnt  <= acc_cnt + 1;
    if (out_valid && in_ready)  bp_viol  <= bp_viol + 1;
    if (out_valid && !out_ready) hold_cnt <= hold_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0]  len;
    logic [4:0]   shift;
    logic [511:0] line [4];
    logic [511:0] exp;
    logic [15:0]  exp_sat;
  } vec_t;

  vec_t         vecs [5];
  logic [511:0] gap_lines [5];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    cfg_start = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input logic [15:0] len, input logic [4:0] sh);
    cfg_start  = 1'b1;
    cfg_length = len;
    cfg_shift  = sh;
    tick();
    cfg_start = 1'b0;
  endtask

  // Holds one line valid until it handshakes; returns just after the accepting edge.
  task automatic push(input logic [511:0] d);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget);
    int n;
    n = 0;
    while (res_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check("result_count", res_q.size(), target);
  endtask

  function automatic logic [511:0] put_in(input logic [511:0] d, input int lane,
                                          input logic [15:0] a, input logic [15:0] b);
    logic [511:0] r;
    r = d;
    r[32*lane +: 16]    = a;
    r[32*lane+16 +: 16] = b;
    return r;
  endfunction

  function automatic logic [511:0] put_out(input logic [511:0] d, input int lane, input logic [15:0] v);
    logic [511:0] r;
    r = d;
    r[16*lane +: 16] = v;
    return r;
  endfunction

  // Reference dot product over gap_lines: exact wide sums, floor shift, clamp.
  function automatic void model(input int n, input int sh, output logic [511:0] o, output logic [15:0] s);
    o = '0;
    s = '0;
    for (int i = 0; i < L; i++) begin
      longint acc;
      longint r;
      logic signed [15:0] a, b;
      acc = 0;
      for (int l = 0; l < n; l++) begin
        a = gap_lines[l][32*i +: 16];
        b = gap_lines[l][32*i+16 +: 16];
        acc += longint'(a) * longint'(b);
      end
      r = acc >>> sh;
      if (r > 32767) begin
        r = 32767;
        s[i] = 1'b1;
      end else if (r < -32768) begin
        r = -32768;
        s[i] = 1'b1;
      end
      o[16*i +: 16] = r[15:0];
    end
  endfunction

  initial begin
    logic [511:0] d, e, m_out;
    logic [15:0]  m_sat;
    int base_r, base_d, base_a, base_bp, base_h, h, n, ev;

    // ---------------- vector table ----------------
    for (int v = 0; v < 5; v++) begin
      for (int l = 0; l < 4; l++) vecs[v].line[l] = '0;
      vecs[v].exp     = '0;
      vecs[v].exp_sat = '0;
    end
    // Q8: 1.0 * 2.0 over 4 lines, >>8 -> 8.0 = 0x0800 per lane
    d = '0;
    e = '0;
    for (int i = 0; i < L; i++) begin
      d = put_in(d, i, 16'h0100, 16'h0200);
      e = put_out(e, i, 16'h0800);
    end
    vecs[0].len = 16'd4; vecs[0].shift = 5'd8;
    for (int l = 0; l < 4; l++) vecs[0].line[l] = d;
    vecs[0].exp = e;
    // positive clamp on lane 0, small negative product on lane 1
    vecs[1].len = 16'd1; vecs[1].shift = 5'd0;
    vecs[1].line[0] = put_in(put_in('0, 0, 16'h7FFF, 16'h7FFF), 1, 16'hFFFD, 16'h0005);
    vecs[1].exp     = put_out(put_out('0, 0, 16'h7FFF), 1, 16'hFFF1);
    vecs[1].exp_sat = 16'h0001;
    // lane k: (k, -1) x3 -> -3k
    d = '0;
    e = '0;
    for (int k = 0; k < L; k++) begin
      ev = -3 * k;
      d = put_in(d, k, 16'(k), 16'hFFFF);
      e = put_out(e, k, ev[15:0]);
    end
    vecs[2].len = 16'd3; vecs[2].shift = 5'd0;
    for (int l = 0; l < 3; l++) vecs[2].line[l] = d;
    vecs[2].exp = e;
    // shift 4: floor of negatives, positive and negative clamps
    d = put_in('0, 0, 16'hFFFF, 16'h0001);
    d = put_in(d, 1, 16'h8000, 16'h8000);
    d = put_in(d, 2, 16'h8000, 16'h7FFF);
    d = put_in(d, 3, 16'h0064, 16'hFFF9);
    vecs[3].len = 16'd2; vecs[3].shift = 5'd4;
    vecs[3].line[0] = d;
    vecs[3].line[1] = d;
    vecs[3].exp = put_out(put_out(put_out(put_out('0, 0, 16'hFFFF), 1, 16'h7FFF), 2, 16'h8000), 3, 16'hFFA8);
    vecs[3].exp_sat = 16'h0006;
    // length 0 behaves as length 1
    vecs[4].len = 16'd0; vecs[4].shift = 5'd0;
    vecs[4].line[0] = put_in(put_in('0, 0, 16'h0003, 16'h0004), 15, 16'hFFFE, 16'h0007);
    vecs[4].exp     = put_out(put_out('0, 0, 16'h000C), 15, 16'hFFF2);

    // ---------------- reset state ----------------
    do_reset();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_sat_flags", sat_flags, '0);

    for (int v = 0; v < 5; v++) begin
      int nl;
      do_reset();
      start(vecs[v].len, vecs[v].shift);
      nl     = (vecs[v].len == 16'd0) ? 1 : int'(vecs[v].len);
      base_r = res_q.size();
      base_d = done_cnt;
      for (int l = 0; l < nl; l++) push(vecs[v].line[l]);
      wait_results(base_r + 1, 40);
      tick();
      tick();
      if (res_q.size() > base_r) check($sformatf("vec%0d_data", v), res_q[base_r], vecs[v].exp);
      check($sformatf("vec%0d_sat", v), sat_flags, vecs[v].exp_sat);
      check($sformatf("vec%0d_done", v), done_cnt - base_d, 1);
      check($sformatf("vec%0d_busy_ready", v), {busy, in_ready}, 2'b11);
    end

    // ---------------- streaming with output backpressure ----------------
    do_reset();
    start(16'd2, 5'd0);
    start(16'd1, 5'd3);    // must be ignored: unit already busy
    base_r  = res_q.size();
    base_d  = done_cnt;
    base_a  = acc_cnt;
    base_bp = bp_viol;
    base_h  = hold_cnt;
    fork
      begin
        for (int j = 0; j < 8; j++)
          push(put_in(put_in('0, 0, 16'(j + 1), 16'd1), 1, 16'(j), 16'd2));
      end
      begin
        n = 0;
        while (res_q.size() < base_r + 1 && n < 100) begin
          tick();
          n++;
        end
        out_ready = 1'b0;
        repeat (10) tick();
        out_ready = 1'b1;
      end
    join
    wait_results(base_r + 4, 100);
    tick();
    tick();
    for (int r = 0; r < 4; r++) begin
      e = put_out(put_out('0, 0, 16'(4 * r + 3)), 1, 16'(8 * r + 2));
      if (res_q.size() > base_r + r) check($sformatf("stream_res%0d", r), res_q[base_r + r], e);
    end
    check("stream_done", done_cnt - base_d, 4);
    check("stream_accepts", acc_cnt - base_a, 8);
    check("stream_ready_during_hold", bp_viol - base_bp, 0);
    check("stream_hold_seen", (hold_cnt - base_h) > 0, 1'b1);

    // ---------------- gaps on in_valid, latency ----------------
    do_reset();
    start(16'd5, 5'd2);
    for (int l = 0; l < 5; l++) begin
      d = '0;
      for (int i = 0; i < L; i++) begin
        int ai, bi;
        ai = int'($urandom_range(0, 600)) - 300;
        bi = int'($urandom_range(0, 600)) - 300;
        d = put_in(d, i, ai[15:0], bi[15:0]);
      end
      gap_lines[l] = d;
    end
    model(5, 2, m_out, m_sat);
    base_r = res_q.size();
    for (int l = 0; l < 5; l++) begin
      push(gap_lines[l]);
      if (l < 4) repeat (1 + $urandom_range(0, 2)) tick();
    end
    h = cyc;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    // out_valid must rise at edge H+ML+1, i.e. be high during cycle t+ML+2
    check("gap_latency", cyc - h, ML + 1);
    wait_results(base_r + 1, 40);
    tick();
    if (res_q.size() > base_r) check("gap_data", res_q[base_r], m_out);
    check("gap_sat", sat_flags, m_sat);

    // ---------------- reset mid-operation ----------------
    do_reset();
    start(16'd6, 5'd0);
    d = '0;
    for (int i = 0; i < L; i++) d = put_in(d, i, 16'd1000, 16'd1000);
    push(d);
    push(d);
    push(d);
    reset = 1'b1;
    tick();
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, '0);
    tick();
    reset = 1'b0;
    start(16'd2, 5'd0);
    d = '0;
    e = '0;
    for (int i = 0; i < L; i++) begin
      d = put_in(d, i, 16'd2, 16'd3);
      e = put_out(e, i, 16'd12);
    end
    base_r = res_q.size();
    push(d);
    push(d);
    wait_results(base_r + 1, 40);
    tick();
    if (res_q.size() > base_r) check("midrst_fresh_result", res_q[base_r], e);
    check("midrst_sat", sat_flags, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
